// File: rtl/clock_reset_pkg.sv
// Shared definitions for the reset tree: sequencer state encodings and default timing constants.
package clock_reset_pkg;

    // The encoding doubles as the output pair {div_reset, core_reset}.
    typedef enum logic [1:0] {
        SEQ_RUN         = 2'b00,
        SEQ_RELEASE_DIV = 2'b01,
        SEQ_ILLEGAL     = 2'b10,
        SEQ_ASSERT_ALL  = 2'b11
    } seq_state_e;

    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_DEBOUNCE_CYCLES  = 16;
    localparam int DEF_DIV_RESET_CYCLES = 4;
    localparam int DEF_CORE_HOLD_CYCLES = 8;
    localparam int DEF_CNT_W            = 8;
    localparam int RESET_COUNT_W        = 8;

    function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes the asynchronous reset button and accepts a level change only after it has
// been stable for DEBOUNCE_CYCLES cycles; db_rise pulses for one cycle with each accepted press.
module button_debouncer
    import clock_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic db,
    output logic db_rise
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   db_q;
    logic                   rise_q;
    logic                   b_s;

    assign b_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (b_s == db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                // Mismatch has persisted long enough: adopt the new level.
                db_q     <= b_s;
                rise_q   <= b_s;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign db      = db_q;
    assign db_rise = rise_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds the clock divider in reset first, then releases the core
// once the divided clocks run; each accepted button press restarts the sequence.
module reset_sequencer
    import clock_reset_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int DIV_RESET_CYCLES = DEF_DIV_RESET_CYCLES,
    parameter int CORE_HOLD_CYCLES = DEF_CORE_HOLD_CYCLES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     button_in,
    output logic                     div_reset,
    output logic                     core_reset,
    output logic [1:0]               seq_state,
    output logic [RESET_COUNT_W-1:0] reset_count
);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_HOLD_CYCLES - 1);

    seq_state_e               state_q;
    logic [CNT_W-1:0]         seq_cnt_q;
    logic [RESET_COUNT_W-1:0] press_cnt_q;
    logic                     db;
    logic                     db_rise;
    logic [1:0]               state_bits;

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .button_in (button_in),
        .db        (db),
        .db_rise   (db_rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= SEQ_ASSERT_ALL;
            seq_cnt_q   <= '0;
            press_cnt_q <= '0;
        end else begin
            if (db_rise) begin
                press_cnt_q <= sat_inc(press_cnt_q);
            end
            case (state_q)
                SEQ_ASSERT_ALL: begin
                    // A held button parks the sequence here with the counter at zero.
                    if (db) begin
                        seq_cnt_q <= '0;
                    end else if (seq_cnt_q == DIV_LAST) begin
                        state_q   <= SEQ_RELEASE_DIV;
                        seq_cnt_q <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                SEQ_RELEASE_DIV: begin
                    if (db_rise) begin
                        state_q   <= SEQ_ASSERT_ALL;
                        seq_cnt_q <= '0;
                    end else if (seq_cnt_q == CORE_LAST) begin
                        state_q   <= SEQ_RUN;
                        seq_cnt_q <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                SEQ_RUN: begin
                    if (db_rise) begin
                        state_q   <= SEQ_ASSERT_ALL;
                        seq_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= SEQ_ASSERT_ALL;
                    seq_cnt_q <= '0;
                end
            endcase
        end
    end

    assign state_bits  = state_q;
    assign div_reset   = state_bits[1];
    assign core_reset  = state_bits[0];
    assign seq_state   = state_bits;
    assign reset_count = press_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expectations are queued with the edge they apply to
// and compared when the run reaches that edge.
module tb_reset_sequencer;

    localparam logic [1:0] ST_ALL = 2'b11;
    localparam logic [1:0] ST_DIV = 2'b01;
    localparam logic [1:0] ST_RUN = 2'b00;

    logic       clock;
    logic       reset;
    logic       btn;
    logic       fbtn;
    logic       m_div, m_core, f_div, f_core;
    logic [1:0] m_state, f_state;
    logic [7:0] m_cnt, f_cnt;

    int edge_n   = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        int          at;
        bit          fast;
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];

    reset_sequencer u_dut (
        .clock       (clock),
        .reset       (reset),
        .button_in   (btn),
        .div_reset   (m_div),
        .core_reset  (m_core),
        .seq_state   (m_state),
        .reset_count (m_cnt)
    );

    // Short debounce so a press can land inside the RELEASE_DIV window.
    reset_sequencer #(.DEBOUNCE_CYCLES(2)) u_fast (
        .clock       (clock),
        .reset       (reset),
        .button_in   (fbtn),
        .div_reset   (f_div),
        .core_reset  (f_core),
        .seq_state   (f_state),
        .reset_count (f_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) edge_n++;

    function automatic logic [11:0] mk(input logic [1:0] st, input int cnt);
        logic [7:0] c;
        c = cnt[7:0];
        return {st[1], st[0], st, c};
    endfunction

    task automatic adv_to(input int n);
        while (edge_n < n) @(negedge clock);
    endtask

    task automatic push(input string tag, input int at, input bit fast, input logic [11:0] exp);
        exp_t e;
        e.tag = tag; e.at = at; e.fast = fast; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain_until(input int lim);
        exp_t        e;
        logic [11:0] obs;
        while (sb_q.size() > 0 && sb_q[0].at <= lim) begin
            e = sb_q.pop_front();
            adv_to(e.at);
            obs = e.fast ? {f_div, f_core, f_state, f_cnt} : {m_div, m_core, m_state, m_cnt};
            n_checks++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s edge %0d: observed div,core,state,count=%h required %h",
                        e.tag, e.at, obs, e.exp);
            $display("check %-14s edge %0d %s obs=%h exp=%h", e.tag, e.at,
                     e.fast ? "fast" : "main", obs, e.exp);
        end
        adv_to(lim);
    endtask

    task automatic chk_now(input string tag, input bit fast, input logic [11:0] exp);
        push(tag, edge_n, fast, exp);
        drain_until(edge_n);
    endtask

    initial begin
        int base, s, r1, exp_cnt;
        reset = 1'b1;
        btn   = 1'b0;
        fbtn  = 1'b0;
        repeat (3) @(negedge clock);
        chk_now("por_hold", 1'b0, mk(ST_ALL, 0));
        chk_now("por_hold_f", 1'b1, mk(ST_ALL, 0));

        // Power-up sequence on both instances; fast one gets a press during RELEASE_DIV.
        reset = 1'b0;
        base  = edge_n;
        push("por_e3",      base + 3,  1'b0, mk(ST_ALL, 0));
        push("por_e4",      base + 4,  1'b0, mk(ST_DIV, 0));
        push("rdiv_pre",    base + 6,  1'b1, mk(ST_DIV, 0));
        push("rdiv_press",  base + 7,  1'b1, mk(ST_ALL, 1));
        push("por_e11",     base + 11, 1'b0, mk(ST_DIV, 0));
        push("por_e12",     base + 12, 1'b0, mk(ST_RUN, 0));
        push("rdiv_e13",    base + 13, 1'b1, mk(ST_ALL, 1));
        push("rdiv_e14",    base + 14, 1'b1, mk(ST_DIV, 1));
        push("rdiv_e21",    base + 21, 1'b1, mk(ST_DIV, 1));
        push("rdiv_e22",    base + 22, 1'b1, mk(ST_RUN, 1));
        drain_until(base + 2);
        fbtn = 1'b1;
        drain_until(base + 6);
        fbtn = 1'b0;
        drain_until(base + 22);

        // Bounce rejection: 5-high / 3-low pulses never reach the debounce threshold.
        for (int p = 0; p < 10; p++) begin
            btn = 1'b1;
            adv_to(edge_n + 5);
            btn = 1'b0;
            adv_to(edge_n + 3);
            chk_now("bounce", 1'b0, mk(ST_RUN, 0));
        end
        adv_to(edge_n + 20);
        chk_now("bounce_settle", 1'b0, mk(ST_RUN, 0));

        // Clean 30-cycle press from RUN.
        btn = 1'b1;
        s   = edge_n + 1;
        push("press_e18",  s + 17, 1'b0, mk(ST_RUN, 0));
        push("press_e19",  s + 18, 1'b0, mk(ST_ALL, 1));
        push("press_held", s + 29, 1'b0, mk(ST_ALL, 1));
        drain_until(s + 29);
        btn = 1'b0;
        r1  = edge_n + 1;
        push("rel_hold",   r1 + 20, 1'b0, mk(ST_ALL, 1));
        push("rel_div",    r1 + 21, 1'b0, mk(ST_DIV, 1));
        push("rel_core_h", r1 + 28, 1'b0, mk(ST_DIV, 1));
        push("rel_run",    r1 + 29, 1'b0, mk(ST_RUN, 1));
        drain_until(r1 + 29);

        // Bring the press count to 5, then let the sequence finish.
        for (int k = 2; k <= 5; k++) begin
            btn = 1'b1;
            adv_to(edge_n + 20);
            btn = 1'b0;
            adv_to(edge_n + 20);
            chk_now("press_n", 1'b0, mk(ST_ALL, k));
        end
        adv_to(edge_n + 15);
        chk_now("run_cnt5", 1'b0, mk(ST_RUN, 5));

        // Asynchronous reset between edges takes effect without a clock edge.
        #2 reset = 1'b1;
        #1;
        chk_now("async_rst", 1'b0, mk(ST_ALL, 0));
        chk_now("async_rst_f", 1'b1, mk(ST_ALL, 0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Saturation of the press counter.
        for (int n = 1; n <= 260; n++) begin
            btn = 1'b1;
            adv_to(edge_n + 20);
            btn = 1'b0;
            adv_to(edge_n + 20);
            exp_cnt = (n > 255) ? 255 : n;
            chk_now("sat", 1'b0, mk(ST_ALL, exp_cnt));
        end
        chk_now("fast_idle", 1'b1, mk(ST_RUN, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates the staged reset tree for the single-cycle processor. It sits directly upstream of the clock divider: it drives the divider's reset first, then releases the core/memory reset once the divided clocks are running. It also accepts a user reset button, which is asynchronous and bouncy, synchronizes and debounces it, and re-runs the full sequence on each accepted press.

## Interface
Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on button_in; must be ≥2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a level change on the button; must be ≥1.
- DIV_RESET_CYCLES, 4, clock edges div_reset is held after the sequence starts; must be ≥1.
- CORE_HOLD_CYCLES, 8, clock edges core_reset is held after div_reset drops; must be ≥2, so the divider's output-enable flop is set before the core runs.
- CNT_W, 8, width of the internal sequence counter; must hold max(DIV_RESET_CYCLES, CORE_HOLD_CYCLES, DEBOUNCE_CYCLES).

Ports:
- clock  in  1  master clock, the undivided clock fed to the clock divider.
- reset  in  1  global reset; asynchronous, active-high.
- button_in  in  1  user reset request; asynchronous, active-high, may bounce.
- div_reset  out  1  reset to the clock divider; active-high.
- core_reset  out  1  reset to the processor, register file and memories; active-high.
- seq_state  out  2  current sequencer state, for debug.
- reset_count  out  8  number of accepted button presses; saturates at 255.

## Operation
- The state register is the output: div_reset = state[1] and core_reset = state[0]. Both outputs therefore come straight from flops and are glitch-free.
- States:
  - ASSERT_ALL = 2'b11.
  - RELEASE_DIV = 2'b01.
  - RUN = 2'b00.
  - 2'b10 is illegal and recovers to ASSERT_ALL on the next edge.
- Reset values:
  - state = ASSERT_ALL, so div_reset=1, core_reset=1, seq_state=2'b11.
  - reset_count = 0.
  - Sequence counter = 0.
  - Synchronizer flops, debounce counter and the debounced level db all = 0.
- Debounce:
  - b_s is the output of the last synchronizer stage.
  - If b_s == db, the debounce counter clears.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 with b_s still != db, db <= b_s and the counter clears.
- Transitions, evaluated on each rising edge:
  - ASSERT_ALL:
    - If db=1, hold the state and keep the sequence counter at 0.
    - Otherwise increment the counter. At DIV_RESET_CYCLES-1, go to RELEASE_DIV and clear the counter.
  - RELEASE_DIV:
    - If db rises, go to ASSERT_ALL and clear the counter.
    - Otherwise increment. At CORE_HOLD_CYCLES-1, go to RUN and clear the counter.
  - RUN:
    - If db rises, go to ASSERT_ALL.
- A db rising edge in any state counts as an accepted press: reset_count increments, saturating at 255. A press accepted during ASSERT_ALL is counted but does not change the state.
- Asserting reset at any time forces all reset values immediately, without waiting for a clock edge. The sequence restarts from the first rising edge after reset deasserts.

## Timing
- After reset deasserts, with button_in low:
  - div_reset falls after the DIV_RESET_CYCLES-th rising edge.
  - core_reset falls CORE_HOLD_CYCLES edges after that.
  - With default parameters: div_reset falls on edge 4 and core_reset on edge 12.
- Button press latency: from the edge that first samples button_in high to div_reset/core_reset = 1 takes SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges. With default parameters this is 19.
- Button pulses or bounces shorter than DEBOUNCE_CYCLES cycles after synchronization are ignored: no state change and no count.
- A held button keeps both resets asserted. Release takes SYNC_STAGES + DEBOUNCE_CYCLES edges for db to fall, then the full DIV_RESET_CYCLES + CORE_HOLD_CYCLES sequence.
- There is no combinational path from any input to any output.

## Structure
- Package clock_reset_pkg holds:
  - The state encodings SEQ_ASSERT_ALL, SEQ_RELEASE_DIV and SEQ_RUN.
  - The default parameter constants.
  - The RESET_COUNT_W = 8 constant.
- Sub-module button_debouncer contains the synchronizer chain and the debounce counter.
  - Inputs: clock, reset, button_in.
  - Outputs: db and db_rise.
  - Parameters: SYNC_STAGES and DEBOUNCE_CYCLES.
- reset_sequencer contains the FSM, the sequence counter and reset_count.

## Test plan
- Power-up: assert reset for 3 cycles, then release with button_in=0. Require div_reset 1→0 at edge 4, core_reset 1→0 at edge 12, seq_state 11→01→00, reset_count=0.
- Clean press in RUN: hold button_in=1 for 30 cycles. Require both resets=1 at edge 19 after the first sample and reset_count=1. After release, require div_reset to fall 4 edges after db falls and core_reset 8 edges after that.
- Bounce rejection: in RUN, drive button_in with ten 5-cycle high / 3-cycle low pulses. Require no change to the outputs and reset_count=0.
- Press during RELEASE_DIV: accept a press while seq_state=01. Require a return to 11 with the counter cleared, reset_count incremented, and a full 4+8 sequence afterwards.
- Mid-operation reset: assert reset asynchronously, between clock edges, while in RUN with reset_count=5. Require div_reset=core_reset=1 immediately and reset_count=0.
- Saturation: accept 260 presses. Require reset_count to stop at 255.
